// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES/SNES pad scanner: scan FSM states,
// button bit positions and the pad/button flat-index helper.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_HI = 3'd2,
    CLK_LO = 3'd3,
    DONE   = 3'd4
  } scan_state_t;

  // NES frame order (first bit shifted out is A)
  localparam int BTN_A      = 32'd0;
  localparam int BTN_B      = 32'd1;
  localparam int BTN_SELECT = 32'd2;
  localparam int BTN_START  = 32'd3;
  localparam int BTN_UP     = 32'd4;
  localparam int BTN_DOWN   = 32'd5;
  localparam int BTN_LEFT   = 32'd6;
  localparam int BTN_RIGHT  = 32'd7;

  // SNES frame order; bits 12..15 carry no buttons and are reported as read
  localparam int SNES_B      = 32'd0;
  localparam int SNES_Y      = 32'd1;
  localparam int SNES_SELECT = 32'd2;
  localparam int SNES_START  = 32'd3;
  localparam int SNES_UP     = 32'd4;
  localparam int SNES_DOWN   = 32'd5;
  localparam int SNES_LEFT   = 32'd6;
  localparam int SNES_RIGHT  = 32'd7;
  localparam int SNES_A      = 32'd8;
  localparam int SNES_X      = 32'd9;
  localparam int SNES_L      = 32'd10;
  localparam int SNES_R      = 32'd11;

  function automatic int pad_bit_index(input int pad, input int button, input int bits);
    return pad * bits + button;
  endfunction

endpackage

// File: rtl/nes_pad_scanner_chk.sv
// Protocol invariants of the pad scanner outputs, written as concurrent
// properties so they can be attached to any instance.
module nes_pad_scanner_chk #(
  parameter int W = 16
) (
  input logic         clk,
  input logic         reset,
  input logic         pad_latch,
  input logic         pad_clk,
  input logic         frame_valid,
  input logic         busy,
  input logic [W-1:0] pressed,
  input logic [W-1:0] released
);

  a_latch_clk_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(pad_latch && pad_clk))
    else $error("pad_latch and pad_clk high together");

  a_frame_after_busy: assert property (@(posedge clk) disable iff (reset)
    frame_valid |-> $past(busy))
    else $error("frame_valid without busy in the previous cycle");

  a_frame_single_cycle: assert property (@(posedge clk) disable iff (reset)
    frame_valid |=> !frame_valid)
    else $error("frame_valid wider than one cycle");

  a_edges_with_frame: assert property (@(posedge clk) disable iff (reset)
    ((|pressed) || (|released)) |-> frame_valid)
    else $error("pressed/released pulse outside a frame_valid cycle");

endmodule

// File: rtl/nes_poll_timer.sv
// Enable-gated poll-rate counter; tick marks the cycle on which the count
// wraps back to zero and therefore the start of a new scan.
module nes_poll_timer #(
  parameter int POLL_PERIOD = 419583
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(POLL_PERIOD - 1);

  logic [TW-1:0] timer_r;

  // Free-running 0..POLL_PERIOD-1 count, parked at zero while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_r <= '0;
    end else if (!enable) begin
      timer_r <= '0;
    end else if (timer_r == LAST) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1'b1);
    end
  end

  assign tick = enable && (timer_r == LAST);

endmodule

// File: rtl/nes_pad_scanner.sv
// Multi-pad NES/SNES reader: drives a shared latch/clock pair, shifts in one
// active-low data line per pad and publishes per-frame button words and edges.
module nes_pad_scanner #(
  parameter int NUM_PADS    = 2,
  parameter int BITS        = 8,
  parameter int CLK_DIV     = 150,
  parameter int POLL_PERIOD = 419583
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_PADS-1:0]      pad_data,
  output logic                     pad_latch,
  output logic                     pad_clk,
  output logic [NUM_PADS*BITS-1:0] buttons,
  output logic [NUM_PADS*BITS-1:0] pressed,
  output logic [NUM_PADS*BITS-1:0] released,
  output logic                     frame_valid,
  output logic                     busy
);
  import nes_pad_pkg::*;

  localparam int W    = NUM_PADS * BITS;
  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam int BI_W = $clog2(BITS);

  localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [BI_W-1:0] BIT_LAST   = BI_W'(BITS - 1);

  // The scan must finish before the next tick can arrive
  if (POLL_PERIOD <= 2 * CLK_DIV * BITS + 1) begin : g_bad_poll_period
    $error("nes_pad_scanner: POLL_PERIOD must exceed 2*CLK_DIV*BITS+1");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("nes_pad_scanner: CLK_DIV must be at least 1");
  end
  if (BITS != 8 && BITS != 16) begin : g_bad_bits
    $error("nes_pad_scanner: BITS must be 8 or 16");
  end
  if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_num_pads
    $error("nes_pad_scanner: NUM_PADS must be 1..4");
  end

  scan_state_t     state_r;
  logic [PH_W-1:0] phase_r;
  logic [BI_W-1:0] bit_r;
  logic [W-1:0]    shift_r;
  logic [W-1:0]    buttons_r;
  logic [W-1:0]    pressed_r;
  logic [W-1:0]    released_r;
  logic            pad_latch_r;
  logic            pad_clk_r;
  logic            frame_valid_r;
  logic            busy_r;
  logic            tick_s;

  nes_poll_timer #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_poll_timer (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick_s)
  );

  // Scan sequencer: latch pulse, BITS-1 clock pulses, then publish the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      phase_r       <= '0;
      bit_r         <= '0;
      shift_r       <= '0;
      buttons_r     <= '0;
      pressed_r     <= '0;
      released_r    <= '0;
      pad_latch_r   <= 1'b0;
      pad_clk_r     <= 1'b0;
      frame_valid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      pressed_r     <= '0;
      released_r    <= '0;
      frame_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            state_r     <= LATCH;
            phase_r     <= '0;
            pad_latch_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        LATCH: begin
          if (phase_r == LATCH_LAST) begin
            // Bit 0 is presented while the latch is still high
            for (int p = 0; p < NUM_PADS; p++) begin
              shift_r[pad_bit_index(p, 0, BITS)] <= ~pad_data[p];
            end
            phase_r     <= '0;
            bit_r       <= BI_W'(1'b1);
            pad_latch_r <= 1'b0;
            pad_clk_r   <= 1'b1;
            state_r     <= CLK_HI;
          end else begin
            phase_r <= phase_r + PH_W'(1'b1);
          end
        end
        CLK_HI: begin
          if (phase_r == HALF_LAST) begin
            phase_r   <= '0;
            pad_clk_r <= 1'b0;
            state_r   <= CLK_LO;
          end else begin
            phase_r <= phase_r + PH_W'(1'b1);
          end
        end
        CLK_LO: begin
          if (phase_r == HALF_LAST) begin
            for (int p = 0; p < NUM_PADS; p++) begin
              shift_r[pad_bit_index(p, int'(bit_r), BITS)] <= ~pad_data[p];
            end
            phase_r <= '0;
            if (bit_r == BIT_LAST) begin
              state_r <= DONE;
            end else begin
              bit_r     <= bit_r + BI_W'(1'b1);
              pad_clk_r <= 1'b1;
              state_r   <= CLK_HI;
            end
          end else begin
            phase_r <= phase_r + PH_W'(1'b1);
          end
        end
        DONE: begin
          buttons_r     <= shift_r;
          pressed_r     <= shift_r & ~buttons_r;
          released_r    <= ~shift_r & buttons_r;
          frame_valid_r <= 1'b1;
          busy_r        <= 1'b0;
          bit_r         <= '0;
          state_r       <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          phase_r     <= '0;
          bit_r       <= '0;
          pad_latch_r <= 1'b0;
          pad_clk_r   <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign pad_latch   = pad_latch_r;
  assign pad_clk     = pad_clk_r;
  assign buttons     = buttons_r;
  assign pressed     = pressed_r;
  assign released    = released_r;
  assign frame_valid = frame_valid_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_nes_pad_scanner.sv
// Scoreboard bench for nes_pad_scanner: an 8-bit two-pad instance and a
// 16-bit four-pad instance, each fed by a behavioural shift-register pad model.
module tb_nes_pad_scanner;

  localparam int CD     = 2;
  localparam int PP     = 64;
  localparam int NP     = 2;
  localparam int B      = 8;
  localparam int W      = NP * B;
  localparam int PP16   = 96;
  localparam int NP16   = 4;
  localparam int B16    = 16;
  localparam int W16    = NP16 * B16;
  localparam int SCAN8  = 2 * CD * B + 1;
  localparam int SCAN16 = 2 * CD * B16 + 1;

  typedef struct packed {
    logic [W-1:0] btn;
    logic [W-1:0] prs;
    logic [W-1:0] rel;
  } exp8_t;

  typedef struct packed {
    logic [W16-1:0] btn;
    logic [W16-1:0] prs;
    logic [W16-1:0] rel;
  } exp16_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic enable16 = 1'b0;

  logic [NP-1:0]   pad_data8;
  logic            pad_latch8, pad_clk8, fv8, busy8;
  logic [W-1:0]    buttons8, pressed8, released8;
  logic [NP16-1:0] pad_data16;
  logic            pad_latch16, pad_clk16, fv16, busy16;
  logic [W16-1:0]  buttons16, pressed16, released16;

  logic [B-1:0]   raw8  [NP];
  logic [B16-1:0] raw16 [NP16];
  int idx8  = 0;
  int idx16 = 0;

  exp8_t  q8[$];
  exp16_t q16[$];
  logic [W-1:0]   prev8;
  logic [W16-1:0] prev16;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nes_pad_scanner #(.NUM_PADS(NP), .BITS(B), .CLK_DIV(CD), .POLL_PERIOD(PP)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .pad_data(pad_data8),
    .pad_latch(pad_latch8), .pad_clk(pad_clk8), .buttons(buttons8),
    .pressed(pressed8), .released(released8), .frame_valid(fv8), .busy(busy8)
  );

  nes_pad_scanner #(.NUM_PADS(NP16), .BITS(B16), .CLK_DIV(CD), .POLL_PERIOD(PP16)) u_dut16 (
    .clk(clk), .reset(reset), .enable(enable16), .pad_data(pad_data16),
    .pad_latch(pad_latch16), .pad_clk(pad_clk16), .buttons(buttons16),
    .pressed(pressed16), .released(released16), .frame_valid(fv16), .busy(busy16)
  );

  nes_pad_scanner_chk #(.W(W)) u_chk8 (
    .clk(clk), .reset(reset), .pad_latch(pad_latch8), .pad_clk(pad_clk8),
    .frame_valid(fv8), .busy(busy8), .pressed(pressed8), .released(released8)
  );

  nes_pad_scanner_chk #(.W(W16)) u_chk16 (
    .clk(clk), .reset(reset), .pad_latch(pad_latch16), .pad_clk(pad_clk16),
    .frame_valid(fv16), .busy(busy16), .pressed(pressed16), .released(released16)
  );

  // Pad model: latch reloads, each rising pad clock advances to the next bit
  always @(posedge pad_latch8 or posedge pad_clk8) begin
    if (pad_latch8) idx8 = 0;
    else idx8 = idx8 + 1;
  end

  always @(posedge pad_latch16 or posedge pad_clk16) begin
    if (pad_latch16) idx16 = 0;
    else idx16 = idx16 + 1;
  end

  always_comb begin
    for (int p = 0; p < NP; p++)
      pad_data8[p] = (idx8 >= 0 && idx8 < B) ? raw8[p][idx8] : 1'b1;
    for (int p = 0; p < NP16; p++)
      pad_data16[p] = (idx16 >= 0 && idx16 < B16) ? raw16[p][idx16] : 1'b1;
  end

  task automatic push8();
    exp8_t e;
    logic [W-1:0] nw;
    for (int p = 0; p < NP; p++) nw[p*B +: B] = ~raw8[p];
    e.btn = nw;
    e.prs = nw & ~prev8;
    e.rel = ~nw & prev8;
    prev8 = nw;
    q8.push_back(e);
  endtask

  task automatic push16();
    exp16_t e;
    logic [W16-1:0] nw;
    for (int p = 0; p < NP16; p++) nw[p*B16 +: B16] = ~raw16[p];
    e.btn = nw;
    e.prs = nw & ~prev16;
    e.rel = ~nw & prev16;
    prev16 = nw;
    q16.push_back(e);
  endtask

  // sel: 0 latch8, 1 fv8, 2 latch16, 3 fv16; n = negedges waited, -1 on timeout
  task automatic wait_sig(input int sel, input int max, output int n);
    logic s;
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      case (sel)
        0: s = pad_latch8;
        1: s = fv8;
        2: s = pad_latch16;
        default: s = fv16;
      endcase
      if (s) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    for (int p = 0; p < NP; p++) raw8[p] = 8'hFF;
    for (int p = 0; p < NP16; p++) raw16[p] = 16'hFFFF;
    prev8 = '0;
    prev16 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pad_latch8, pad_clk8, fv8, busy8} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl8: got %b expected 0000", {pad_latch8, pad_clk8, fv8, busy8});
    end
    n_checks++;
    if ({buttons8, pressed8, released8} !== '0) begin
      n_fail++; $display("FAIL reset_words8: got %h expected 0", {buttons8, pressed8, released8});
    end
    n_checks++;
    if ({pad_latch16, pad_clk16, fv16, busy16, buttons16} !== '0) begin
      n_fail++; $display("FAIL reset_dut16: got %h expected 0", {pad_latch16, pad_clk16, fv16, busy16, buttons16});
    end
  endtask

  task automatic test_first_frame();
    int n;
    exp8_t e;
    logic el, ec, ef, eb;
    raw8[0] = 8'h5A;
    raw8[1] = 8'hFF;
    push8();
    enable = 1'b1;
    reset = 1'b0;
    wait_sig(0, 200, n);
    n_checks++;
    if (n != PP) begin
      n_fail++; $display("FAIL first_latch_latency: got %0d expected %0d", n, PP);
    end
    for (int k = 0; k <= SCAN8 + 1; k++) begin
      if (k > 0) @(negedge clk);
      el = (k < 2*CD);
      ec = (k >= 2*CD) && (k < 2*CD + 2*CD*(B-1)) && (((k - 2*CD) % (2*CD)) < CD);
      ef = (k == SCAN8);
      eb = (k < SCAN8);
      n_checks++;
      if ({pad_latch8, pad_clk8, fv8, busy8} !== {el, ec, ef, eb}) begin
        n_fail++;
        $display("FAIL scan_wave k=%0d: latch/clk/fv/busy got %b expected %b", k,
                 {pad_latch8, pad_clk8, fv8, busy8}, {el, ec, ef, eb});
      end
      if (fv8 && q8.size() > 0) begin
        e = q8.pop_front();
        n_checks++;
        if ({buttons8, pressed8, released8} !== {e.btn, e.prs, e.rel}) begin
          n_fail++;
          $display("FAIL first_frame: btn/prs/rel got %h/%h/%h expected %h/%h/%h",
                   buttons8, pressed8, released8, e.btn, e.prs, e.rel);
        end
      end else if (!ef) begin
        n_checks++;
        if ({pressed8, released8} !== '0) begin
          n_fail++; $display("FAIL pulse_idle k=%0d: got %h expected 0", k, {pressed8, released8});
        end
      end
    end
    n_checks++;
    if (q8.size() != 0) begin
      n_fail++; $display("FAIL first_frame_seen: pending %0d expected 0", q8.size());
      q8.delete();
    end
  endtask

  task automatic test_press_release();
    int n;
    exp8_t e;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) raw8[0] = 8'h5C;
      push8();
      wait_sig(1, 200, n);
      n_checks++;
      if (n < 0) begin
        n_fail++; $display("FAIL frame%0d_timeout: got none expected frame_valid", f);
        q8.delete();
      end else begin
        e = q8.pop_front();
        if ({buttons8, pressed8, released8} !== {e.btn, e.prs, e.rel}) begin
          n_fail++;
          $display("FAIL edge_frame%0d: btn/prs/rel got %h/%h/%h expected %h/%h/%h",
                   f, buttons8, pressed8, released8, e.btn, e.prs, e.rel);
        end
        @(negedge clk);
        n_checks++;
        if ({fv8, pressed8, released8} !== '0 || buttons8 !== e.btn) begin
          n_fail++;
          $display("FAIL pulse_width%0d: fv/prs/rel got %h expected 0, btn %h expected %h",
                   f, {fv8, pressed8, released8}, buttons8, e.btn);
        end
      end
    end
  endtask

  task automatic test_enable_gate();
    int n, hits;
    exp8_t e;
    raw8[0] = 8'h7E;
    push8();
    wait_sig(0, 200, n);
    @(negedge clk);
    enable = 1'b0;
    wait_sig(1, 100, n);
    n_checks++;
    if (n < 0) begin
      n_fail++; $display("FAIL gate_frame: got none expected frame_valid");
      q8.delete();
    end else begin
      e = q8.pop_front();
      if ({buttons8, pressed8, released8} !== {e.btn, e.prs, e.rel}) begin
        n_fail++;
        $display("FAIL gate_frame: btn/prs/rel got %h/%h/%h expected %h/%h/%h",
                 buttons8, pressed8, released8, e.btn, e.prs, e.rel);
      end
    end
    hits = 0;
    repeat (200) begin
      @(negedge clk);
      if (pad_latch8 || busy8) hits++;
    end
    n_checks++;
    if (hits != 0) begin
      n_fail++; $display("FAIL gate_quiet: active cycles got %0d expected 0", hits);
    end
    enable = 1'b1;
    wait_sig(0, 200, n);
    n_checks++;
    if (n != PP) begin
      n_fail++; $display("FAIL reenable_latency: got %0d expected %0d", n, PP);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    bit fv_seen;
    exp8_t e;
    // Entered at the first latch cycle of a scan; CLK_LO of bit 4 is 18 cycles on
    repeat (18) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({pad_latch8, pad_clk8, fv8, busy8, buttons8} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: latch/clk/fv/busy/btn got %b/%h expected 0/0",
               {pad_latch8, pad_clk8, fv8, busy8}, buttons8);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    raw8[0] = 8'h3C;
    prev8 = '0;
    push8();
    fv_seen = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (fv8) fv_seen = 1'b1;
      if (pad_latch8) break;
    end
    n_checks++;
    if (fv_seen || n != PP || !pad_latch8) begin
      n_fail++; $display("FAIL post_reset_latch: fv_seen %0d latency %0d expected 0 and %0d", fv_seen, n, PP);
    end
    wait_sig(1, 100, n);
    n_checks++;
    if (n != SCAN8) begin
      n_fail++; $display("FAIL post_reset_scan_len: got %0d expected %0d", n, SCAN8);
    end
    n_checks++;
    if (q8.size() == 0 || n < 0) begin
      n_fail++; $display("FAIL post_reset_frame: got no frame expected one");
      q8.delete();
    end else begin
      e = q8.pop_front();
      if ({buttons8, pressed8, released8} !== {e.btn, e.prs, e.rel}) begin
        n_fail++;
        $display("FAIL post_reset_frame: btn/prs/rel got %h/%h/%h expected %h/%h/%h",
                 buttons8, pressed8, released8, e.btn, e.prs, e.rel);
      end
    end
  endtask

  task automatic test_snes16();
    int n;
    exp16_t e;
    raw16[2] = 16'h0FFF;
    push16();
    @(negedge clk);
    enable16 = 1'b1;
    wait_sig(2, 300, n);
    n_checks++;
    if (n != PP16) begin
      n_fail++; $display("FAIL snes_latch_latency: got %0d expected %0d", n, PP16);
    end
    for (int f = 0; f < 2; f++) begin
      if (f == 1) begin
        raw16[0] = 16'hFFFE;
        raw16[2] = 16'hFFFF;
        push16();
        wait_sig(2, 300, n);
      end
      wait_sig(3, 100, n);
      n_checks++;
      if (n != SCAN16) begin
        n_fail++; $display("FAIL snes_scan_len%0d: got %0d expected %0d", f, n, SCAN16);
      end
      n_checks++;
      if (n < 0) begin
        n_fail++; $display("FAIL snes_frame%0d: got none expected frame_valid", f);
        q16.delete();
      end else begin
        e = q16.pop_front();
        if ({buttons16, pressed16, released16} !== {e.btn, e.prs, e.rel}) begin
          n_fail++;
          $display("FAIL snes_frame%0d: btn/prs/rel got %h/%h/%h expected %h/%h/%h",
                   f, buttons16, pressed16, released16, e.btn, e.prs, e.rel);
        end
        @(negedge clk);
        n_checks++;
        if ({fv16, pressed16, released16} !== '0) begin
          n_fail++; $display("FAIL snes_pulse%0d: got %h expected 0", f, {fv16, pressed16, released16});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_press_release();
    test_enable_gate();
    test_reset_mid_scan();
    test_snes16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
